rx_move_parser: RTL and testbench

- Sits directly downstream of the 8N1 serial receiver. Consumes its byte strobe (pronto) and received byte (dados_ascii).
- Parses Rubik move notation (U D L R F B, optionally followed by ' or 2) into encoded moves.
- Buffers the moves in an internal FIFO and presents them to the move sequencer through a valid/ready handshake.
- Flags malformed input and FIFO overflow, and pulses at end of sequence (newline).

---
 rtl/rx_move_parser.sv | 150 +++++++++++++++
 tb/tb_rx_move_parser.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_move_parser.sv
// Parses Rubik move notation from the serial receiver byte stream into
// (face, turn) entries queued in a FIFO with a valid/ready consumer port.
module rx_move_parser #(
  parameter  int FIFO_DEPTH = 16,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pronto_rx,
  input  logic [7:0]       dados_rx,
  output logic             move_valid,
  output logic [2:0]       move_face,
  output logic [1:0]       move_turn,
  input  logic             move_ready,
  output logic             fim_seq,
  output logic             erro,
  output logic             overflow,
  output logic [PTR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, PEND, DISCARD} state_t;

  state_t     state_reg, state_next;
  logic [2:0] face_reg, face_next;
  logic       fim_reg, fim_next;
  logic       erro_reg, erro_set;
  logic       ovf_reg;

  logic       is_face, is_prime, is_two, is_sep, is_nl;
  logic [2:0] byte_face;

  logic       commit;
  logic [1:0] commit_turn;

  logic [2:0]       mem_face [FIFO_DEPTH];
  logic [1:0]       mem_turn [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push, pop, full;

  // Byte classification
  always_comb begin
    is_face   = 1'b1;
    byte_face = 3'd0;
    case (dados_rx)
      8'h55:   byte_face = 3'd0;
      8'h44:   byte_face = 3'd1;
      8'h4C:   byte_face = 3'd2;
      8'h52:   byte_face = 3'd3;
      8'h46:   byte_face = 3'd4;
      8'h42:   byte_face = 3'd5;
      default: is_face = 1'b0;
    endcase
    is_prime = (dados_rx == 8'h27);
    is_two   = (dados_rx == 8'h32);
    is_sep   = (dados_rx == 8'h20) || (dados_rx == 8'h0D);
    is_nl    = (dados_rx == 8'h0A);
  end

  always_comb begin
    state_next  = state_reg;
    face_next   = face_reg;
    fim_next    = 1'b0;
    erro_set    = 1'b0;
    commit      = 1'b0;
    commit_turn = 2'b01;
    if (pronto_rx) begin
      fim_next = is_nl;
      case (state_reg)
        IDLE: begin
          if (is_face) begin
            face_next  = byte_face;
            state_next = PEND;
          end else if (!is_sep && !is_nl) begin
            erro_set   = 1'b1;
            state_next = DISCARD;
          end
        end
        PEND: begin
          if (is_prime || is_two || is_sep || is_nl) begin
            commit      = 1'b1;
            commit_turn = is_prime ? 2'b11 : (is_two ? 2'b10 : 2'b01);
            state_next  = IDLE;
          end else if (is_face) begin
            // A new face implicitly terminates the held one as clockwise
            commit    = 1'b1;
            face_next = byte_face;
          end else begin
            erro_set   = 1'b1;
            state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (is_sep || is_nl) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      face_reg  <= 3'd0;
      fim_reg   <= 1'b0;
      erro_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      face_reg  <= face_next;
      fim_reg   <= fim_next;
      if (erro_set) erro_reg <= 1'b1;
    end
  end

  // A pop in the same edge frees a slot, so a full FIFO still accepts the push
  assign full = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop  = (count_reg != '0) && move_ready;
  assign push = commit && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_face[wr_ptr_reg] <= face_reg;
      mem_turn[wr_ptr_reg] <= commit_turn;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (commit && !push) ovf_reg <= 1'b1;
    end
  end

  assign move_valid = (count_reg != '0);
  assign move_face  = move_valid ? mem_face[rd_ptr_reg] : 3'd0;
  assign move_turn  = move_valid ? mem_turn[rd_ptr_reg] : 2'b00;
  assign fim_seq    = fim_reg;
  assign erro       = erro_reg;
  assign overflow   = ovf_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_rx_move_parser.sv
// Randomized and directed bench for rx_move_parser against a queue-based
// model of the move grammar and FIFO.
module tb_rx_move_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       pronto_rx;
  logic [7:0] dados_rx;
  logic       move_valid;
  logic [2:0] move_face;
  logic [1:0] move_turn;
  logic       move_ready;
  logic       fim_seq;
  logic       erro;
  logic       overflow;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  rx_move_parser #(.FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .pronto_rx(pronto_rx), .dados_rx(dados_rx),
    .move_valid(move_valid), .move_face(move_face), .move_turn(move_turn),
    .move_ready(move_ready), .fim_seq(fim_seq), .erro(erro),
    .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  wire [13:0] obs = {move_valid, move_face, move_turn, count, fim_seq, erro, overflow};

  // Model state: queued moves as {face,turn}, parser context, sticky flags
  logic [4:0] mq[$];
  logic [4:0] got[$];
  bit         m_have, m_disc, m_fim, m_erro, m_ovf;
  int         m_held;

  function automatic int face_of(input logic [7:0] b);
    case (b)
      8'h55: return 0;
      8'h44: return 1;
      8'h4C: return 2;
      8'h52: return 3;
      8'h46: return 4;
      8'h42: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [4:0] head;
    head = (mq.size() > 0) ? mq[0] : 5'd0;
    return {mq.size() > 0, head, 5'(mq.size()), m_fim, m_erro, m_ovf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_have = 0; m_disc = 0; m_fim = 0; m_erro = 0; m_ovf = 0; m_held = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit c, output logic [4:0] ent);
    int  f;
    bit  sep, nl;
    f   = face_of(b);
    sep = (b == 8'h20) || (b == 8'h0D);
    nl  = (b == 8'h0A);
    c   = 0;
    ent = 5'd0;
    if (m_disc) begin
      if (sep || nl) m_disc = 0;
    end else if (m_have) begin
      if (b == 8'h27 || b == 8'h32 || sep || nl) begin
        c = 1;
        ent = {3'(m_held), (b == 8'h27) ? 2'b11 : (b == 8'h32) ? 2'b10 : 2'b01};
        m_have = 0;
      end else if (f >= 0) begin
        c = 1;
        ent = {3'(m_held), 2'b01};
        m_held = f;
      end else begin
        m_have = 0; m_erro = 1; m_disc = 1;
      end
    end else if (f >= 0) begin
      m_have = 1; m_held = f;
    end else if (!sep && !nl) begin
      m_erro = 1; m_disc = 1;
    end
  endtask

  // One clock of stimulus; records DUT handshakes and advances the model
  task automatic step(input bit p, input logic [7:0] b, input bit r);
    bit         c;
    logic [4:0] ent;
    pronto_rx  = p;
    dados_rx   = b;
    move_ready = r;
    #1;
    if (move_valid && move_ready) got.push_back({move_face, move_turn});
    @(posedge clock);
    c = 0;
    ent = 5'd0;
    if (p) model_byte(b, c, ent);
    m_fim = p && (b == 8'h0A);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (c) begin
      if (mq.size() < 16) mq.push_back(ent);
      else m_ovf = 1;
    end
    #1;
    pronto_rx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    got.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pronto_rx = 0; dados_rx = 8'h00; move_ready = 0;
    #3;
    total++;
    if (obs !== 14'd0) begin
      $display("FAIL reset_outputs got=%h exp=0", obs); bad++;
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(0, 8'h00, 0);
    total++;
    if (obs !== exp_vec()) begin
      $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec()); bad++;
    end
  endtask

  task automatic test_basic();
    string s = "R U' F2\n";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i], 1);
      total++;
      if (obs !== exp_vec()) begin
        $display("FAIL basic_byte%0d got=%h exp=%h", i, obs, exp_vec()); bad++;
      end
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    total++;
    if (got.size() != 3 || got[0] !== 5'b011_01 || got[1] !== 5'b000_11 || got[2] !== 5'b100_10) begin
      $display("FAIL basic_order got_n=%0d exp_n=3", got.size()); bad++;
    end
    total++;
    if (erro !== 1'b0) begin
      $display("FAIL basic_erro got=%b exp=0", erro); bad++;
    end
  endtask

  task automatic test_face_face();
    string s = "LB\n";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i], 1);
      total++;
      if (obs !== exp_vec()) begin
        $display("FAIL lb_byte%0d got=%h exp=%h", i, obs, exp_vec()); bad++;
      end
    end
    // Move committed by the newline shows up alongside fim_seq
    total++;
    if (!(fim_seq === 1'b1 && move_valid === 1'b1 && move_face === 3'd5 && move_turn === 2'b01)) begin
      $display("FAIL lb_fim_align got=%b%b%0d%b exp=1151", fim_seq, move_valid, move_face, move_turn); bad++;
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    total++;
    if (got.size() != 2 || got[0] !== 5'b010_01 || got[1] !== 5'b101_01) begin
      $display("FAIL lb_order got_n=%0d exp_n=2", got.size()); bad++;
    end
  endtask

  task automatic test_error();
    string s = "2 x R\n";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i], 1);
      total++;
      if (obs !== exp_vec()) begin
        $display("FAIL err_byte%0d got=%h exp=%h", i, obs, exp_vec()); bad++;
      end
      if (i == 0) begin
        total++;
        if (erro !== 1'b1) begin
          $display("FAIL err_first got=%b exp=1", erro); bad++;
        end
      end
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    total++;
    if (got.size() != 1 || got[0] !== 5'b011_01 || erro !== 1'b1) begin
      $display("FAIL err_result got_n=%0d erro=%b exp_n=1 erro=1", got.size(), erro); bad++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, 8'h55, 0);
      step(1, 8'h20, 0);
      total++;
      if (obs !== exp_vec()) begin
        $display("FAIL ovf_pair%0d got=%h exp=%h", i, obs, exp_vec()); bad++;
      end
    end
    total++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      $display("FAIL ovf_full got=%0d/%b exp=16/1", count, overflow); bad++;
    end
    for (int i = 0; i < 18; i++) step(0, 8'h00, 1);
    total++;
    if (got.size() != 16 || count !== 5'd0) begin
      $display("FAIL ovf_drain got_n=%0d count=%0d exp_n=16 count=0", got.size(), count); bad++;
    end
    foreach (got[i]) begin
      total++;
      if (got[i] !== 5'b000_01) begin
        $display("FAIL ovf_entry%0d got=%b exp=00001", i, got[i]); bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'h55, 0);
      step(1, 8'h20, 0);
    end
    step(1, 8'h44, 0);
    step(1, 8'h20, 1);
    total++;
    if (count !== 5'd16 || overflow !== 1'b0 || obs !== exp_vec()) begin
      $display("FAIL b2b_pushpop got=%0d/%b exp=16/0", count, overflow); bad++;
    end
    for (int i = 0; i < 18; i++) step(0, 8'h00, 1);
    total++;
    if (got.size() != 17 || got[16] !== 5'b001_01 || got[15] !== 5'b000_01) begin
      $display("FAIL b2b_wrap got_n=%0d exp_n=17", got.size()); bad++;
    end
  endtask

  task automatic test_reset_pend();
    string s = "U D L F";
    do_reset();
    for (int i = 0; i < s.len(); i++) step(1, s[i], 0);
    total++;
    if (count !== 5'd3) begin
      $display("FAIL rst_pend_pre got=%0d exp=3", count); bad++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (move_valid !== 1'b0 || count !== 5'd0) begin
      $display("FAIL rst_async got=%b/%0d exp=0/0", move_valid, count); bad++;
    end
    model_reset();
    got.delete();
    @(negedge clock);
    reset = 1'b0;
    step(1, 8'h0A, 1);
    total++;
    if (obs !== exp_vec() || fim_seq !== 1'b1) begin
      $display("FAIL rst_nl got=%h exp=%h", obs, exp_vec()); bad++;
    end
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    total++;
    if (got.size() != 0 || fim_seq !== 1'b0) begin
      $display("FAIL rst_nomove got_n=%0d fim=%b exp=0/0", got.size(), fim_seq); bad++;
    end
  endtask

  task automatic test_random();
    logic [7:0] alpha [14] = '{8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42, 8'h27,
                               8'h32, 8'h20, 8'h0D, 8'h0A, 8'h78, 8'h75, 8'h20};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 6, alpha[$urandom_range(0, 13)], $urandom_range(0, 3) != 0);
      total++;
      if (obs !== exp_vec()) begin
        $display("FAIL rand_cycle%0d got=%h exp=%h", i, obs, exp_vec()); bad++;
      end
      if (i == 300) begin
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_face_face();
    test_error();
    test_overflow();
    test_back_to_back();
    test_reset_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
